vproc_unit_dispatcher: RTL

//  In-order scheduler between the decoder and the execution units.
//  - Holds one decoded instruction.
//  - Blocks it on RAW/WAW vector-register hazards or a full unit.
//  - Issues it to the unit selected by its op_unit code.
//  - Sequences UNIT_CFG pseudo-ops: it drains all units first, then fires the config update.

---
 rtl/vproc_unit_dispatcher.sv | 94 +++++++++
 1 files changed

// File: rtl/vproc_unit_dispatcher.sv
// vproc_unit_dispatcher: in-order hazard-checked issue of decoded vector instructions to execution units
module vproc_unit_dispatcher #(
  parameter int UNIT_CNT   = 7,
  parameter int UNIT_DEPTH = 2,
  parameter int ID_W       = 3
) (
  input  logic                  clk_i,
  input  logic                  sync_rst_i,
  input  logic                  instr_valid_i,
  output logic                  instr_ready_o,
  input  logic [ID_W-1:0]       instr_id_i,
  input  logic [2:0]            instr_unit_i,
  input  logic [31:0]           instr_rd_mask_i,
  input  logic [31:0]           instr_wr_mask_i,
  output logic [UNIT_CNT-1:0]   disp_valid_o,
  input  logic [UNIT_CNT-1:0]   disp_ready_i,
  output logic [ID_W-1:0]       disp_id_o,
  input  logic [UNIT_CNT-1:0]   unit_done_i,
  input  logic [UNIT_CNT-1:0]   wr_clr_valid_i,
  input  logic [32*UNIT_CNT-1:0] wr_clr_mask_i,
  output logic [31:0]           pend_wr_o,
  output logic                  cfg_start_o,
  output logic [ID_W-1:0]       cfg_id_o,
  output logic                  idle_o
);
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  logic [1:0]          state;
  logic [ID_W-1:0]     id_q;
  logic [2:0]          unit_q;
  logic [31:0]         rd_q, wr_q, pend_wr, clr_mask;
  logic [2:0]          cnt [UNIT_CNT];
  logic [2:0]          cnt_sel;
  logic [UNIT_CNT-1:0] inc, dec;
  logic                haz, issue_fire, accept, cnt_zero;
  // Select the held unit's counter, merge released write masks and build the one-hot issue request
  always_comb begin
    cnt_sel = '0;
    cnt_zero = 1'b1;
    clr_mask = '0;
    for (int u = 0; u < UNIT_CNT; u++) begin
      cnt_sel = (unit_q == 3'(u)) ? cnt[u] : cnt_sel;
      cnt_zero = cnt_zero & (cnt[u] == 3'd0);
      clr_mask = clr_mask | (wr_clr_valid_i[u] ? wr_clr_mask_i[32*u +: 32] : 32'd0);
    end
    haz = (|((rd_q | wr_q) & pend_wr)) | (cnt_sel == 3'(UNIT_DEPTH));
    disp_valid_o = '0;
    for (int u = 0; u < UNIT_CNT; u++)
      disp_valid_o[u] = (state == S_HOLD) & ~haz & (unit_q == 3'(u));
    issue_fire = |(disp_valid_o & disp_ready_i);
    inc = '0;
    dec = '0;
    for (int u = 0; u < UNIT_CNT; u++) begin
      inc[u] = issue_fire & (unit_q == 3'(u));
      dec[u] = unit_done_i[u] & ((cnt[u] != 3'd0) | inc[u]);
    end
  end
  assign disp_id_o     = (|disp_valid_o) ? id_q : '0;
  assign cfg_start_o   = (state == S_DRAIN) & cnt_zero & ~(|pend_wr);
  assign cfg_id_o      = cfg_start_o ? id_q : '0;
  assign instr_ready_o = (state == S_EMPTY) | issue_fire | cfg_start_o;
  assign accept        = instr_valid_i & instr_ready_o;
  assign idle_o        = (state == S_EMPTY) & cnt_zero & ~(|pend_wr);
  assign pend_wr_o     = pend_wr;
  // Hold register, FSM, pending-write scoreboard and per-unit in-flight counters
  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      state <= S_EMPTY;
      id_q <= '0;
      unit_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      pend_wr <= '0;
      for (int u = 0; u < UNIT_CNT; u++) cnt[u] <= '0;
    end else begin
      if (instr_ready_o) state <= accept ? ((instr_unit_i == 3'd7) ? S_DRAIN : S_HOLD) : S_EMPTY;
      if (accept) begin
        id_q <= instr_id_i;
        unit_q <= instr_unit_i;
        rd_q <= instr_rd_mask_i;
        wr_q <= instr_wr_mask_i;
      end
      pend_wr <= (pend_wr & ~clr_mask) | (issue_fire ? wr_q : 32'd0);
      for (int u = 0; u < UNIT_CNT; u++) cnt[u] <= cnt[u] + 3'(inc[u]) - 3'(dec[u]);
    end
  end
  // A retire pulse from a unit with nothing in flight indicates a protocol error upstream
  always_ff @(posedge clk_i) begin
    if (!sync_rst_i)
      for (int u = 0; u < UNIT_CNT; u++)
        assert (!(unit_done_i[u] && cnt[u] == 3'd0 && !inc[u]));
  end
endmodule
